// File: rtl/cam_pkg.sv
// Shared opcodes, sequencer states and sizing helpers for the CAM job sequencer.
package cam_pkg;

    localparam logic [2:0] OP_IDLE       = 3'd0;
    localparam logic [2:0] OP_UPDATE_ALL = 3'd1;
    localparam logic [2:0] OP_SEARCH     = 3'd2;
    localparam logic [2:0] OP_UPDATE_ONE = 3'd3;

    localparam int CAM_SIZE_DEFAULT   = 256;
    localparam int CAM_BEATS_PER_LOAD = CAM_SIZE_DEFAULT / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_WAIT,
        ST_SEARCH,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // A 512-bit beat carries eight CAM entries.
    function automatic int beats_per_load(input int cam_size);
        return cam_size / 8;
    endfunction

endpackage

// File: rtl/cam_op_sequencer_fifo.sv
// Result FIFO for the CAM sequencer: single clock, synchronous reset,
// push and pop may occur in the same cycle.
module cam_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // The upstream credit scheme must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge aclk) disable iff (areset)
        !(push_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/cam_op_sequencer.sv
// CAM job sequencer: bulk table load, credit-limited search issue, drain through the result FIFO.
// Defining CAM_SEQ_PERF_CNT_EN adds the load_cycles/search_cycles counters.
module cam_op_sequencer
    import cam_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 512,
    parameter int CAM_SIZE       = CAM_SIZE_DEFAULT,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int SEARCH_LATENCY = 4,
    parameter int RESULT_WIDTH   = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     ap_start,
    input  logic [31:0]              num_searches,
    output logic                     busy,
    output logic                     ap_done,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [C_DATA_WIDTH-1:0]  s_tdata,
    output logic [OP_CODE_WIDTH-1:0] cam_state,
    output logic                     cam_tvalid,
    output logic [C_DATA_WIDTH-1:0]  cam_tdata,
    input  logic                     cam_update_all_end,
    input  logic                     cam_m_tvalid,
    input  logic [C_DATA_WIDTH-1:0]  cam_m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [RESULT_WIDTH-1:0]  m_tdata
`ifdef CAM_SEQ_PERF_CNT_EN
   ,output logic [31:0]              load_cycles,
    output logic [31:0]              search_cycles
`endif
);
    localparam int LOAD_BEATS = beats_per_load(CAM_SIZE);
    localparam int BW         = $clog2(LOAD_BEATS + 1);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < SEARCH_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two of at least SEARCH_LATENCY+1");
    end

    seq_state_e        state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [31:0]       search_cnt_q, search_cnt_d;
    logic [31:0]       num_q, num_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              credit;
    logic              issue;
    logic              result_push;
    logic [2:0]        op_d;
    logic              unused_cam_hi;

    assign unused_cam_hi = ^cam_m_tdata[C_DATA_WIDTH-1:RESULT_WIDTH];

    // Results only count while something is outstanding; stragglers after an abort are dropped.
    assign result_push = cam_m_tvalid && (inflight_q != '0);
    assign credit      = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign cam_state   = OP_CODE_WIDTH'(op_d);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign ap_done     = (state_q == ST_DONE);
    assign m_tvalid    = !fifo_empty;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            search_cnt_q <= '0;
            num_q        <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            search_cnt_q <= search_cnt_d;
            num_q        <= num_d;
            inflight_q   <= inflight_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        search_cnt_d = search_cnt_q;
        num_d        = num_q;
        op_d         = OP_IDLE;
        s_tready     = 1'b0;
        cam_tvalid   = 1'b0;
        cam_tdata    = '0;
        issue        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    num_d        = num_searches;
                    beat_cnt_d   = '0;
                    search_cnt_d = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                op_d       = OP_UPDATE_ALL;
                s_tready   = 1'b1;
                cam_tvalid = s_tvalid;
                cam_tdata  = s_tdata;
                if (s_tvalid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BW'(LOAD_BEATS - 1)) state_d = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                op_d = OP_UPDATE_ALL;
                if (cam_update_all_end) state_d = (num_q != '0) ? ST_SEARCH : ST_DONE;
            end
            ST_SEARCH: begin
                op_d      = OP_SEARCH;
                s_tready  = credit;
                cam_tdata = s_tdata;
                if (credit && s_tvalid) begin
                    issue        = 1'b1;
                    cam_tvalid   = 1'b1;
                    search_cnt_d = search_cnt_q + 32'd1;
                    if (search_cnt_q == num_q - 32'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // CAM results only advance while the opcode stays SEARCH.
                op_d = OP_SEARCH;
                if (inflight_q == '0 && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case ({issue, result_push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    cam_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_WIDTH)
    ) u_result_fifo (
        .aclk        (aclk),
        .areset      (areset),
        .push_i      (result_push),
        .push_data_i (cam_m_tdata[RESULT_WIDTH-1:0]),
        .pop_i       (m_tvalid && m_tready),
        .pop_data_o  (m_tdata),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef CAM_SEQ_PERF_CNT_EN
    logic [31:0] load_cycles_q;
    logic [31:0] search_cycles_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            load_cycles_q   <= '0;
            search_cycles_q <= '0;
        end else if (state_q == ST_IDLE && ap_start) begin
            load_cycles_q   <= '0;
            search_cycles_q <= '0;
        end else begin
            if ((state_q == ST_LOAD || state_q == ST_LOAD_WAIT) && load_cycles_q != '1)
                load_cycles_q <= load_cycles_q + 32'd1;
            if ((state_q == ST_SEARCH || state_q == ST_DRAIN) && search_cycles_q != '1)
                search_cycles_q <= search_cycles_q + 32'd1;
        end
    end

    assign load_cycles   = load_cycles_q;
    assign search_cycles = search_cycles_q;
`endif

endmodule

// File: tb/tb_cam_op_sequencer.sv
// Self-checking bench for cam_op_sequencer with a behavioural CAM model and
// a key-to-result scoreboard.
module tb_cam_op_sequencer;
    localparam int DW     = 512;
    localparam int RW     = 32;
    localparam int LAT    = 4;
    localparam int DEPTH  = 16;
    localparam int LOAD_N = 32;
    localparam logic [RW-1:0] RES_KEY = 32'h5A3C_0F96;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic           ap_start = 1'b0;
    logic [31:0]    num_searches = '0;
    logic           busy, ap_done;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [DW-1:0]  s_tdata = '0;
    logic [2:0]     cam_state;
    logic           cam_tvalid;
    logic [DW-1:0]  cam_tdata;
    logic           cam_update_all_end;
    logic           cam_m_tvalid;
    logic [DW-1:0]  cam_m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [RW-1:0]  m_tdata;
`ifdef CAM_SEQ_PERF_CNT_EN
    logic [31:0]    load_cycles, search_cycles;
`endif

    always #5 aclk = ~aclk;

    cam_op_sequencer dut (
        .aclk               (aclk),
        .areset             (areset),
        .ap_start           (ap_start),
        .num_searches       (num_searches),
        .busy               (busy),
        .ap_done            (ap_done),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tdata            (s_tdata),
        .cam_state          (cam_state),
        .cam_tvalid         (cam_tvalid),
        .cam_tdata          (cam_tdata),
        .cam_update_all_end (cam_update_all_end),
        .cam_m_tvalid       (cam_m_tvalid),
        .cam_m_tdata        (cam_m_tdata),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .m_tdata            (m_tdata)
`ifdef CAM_SEQ_PERF_CNT_EN
       ,.load_cycles        (load_cycles),
        .search_cycles      (search_cycles)
`endif
    );

    // CAM model: fixed-latency result pipe, load-complete pulse one cycle after the last table beat.
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];
    int             load_seen = 0;
    logic           upd_end = 1'b0;

    always @(posedge aclk) begin
        pv    <= {pv[LAT-2:0], (cam_tvalid === 1'b1) && (cam_state === 3'd2)};
        pd[0] <= cam_tdata ^ DW'(RES_KEY);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        if (areset) begin
            load_seen <= 0;
            upd_end   <= 1'b0;
        end else if ((cam_tvalid === 1'b1) && (cam_state === 3'd1)) begin
            if (load_seen == LOAD_N - 1) begin
                load_seen <= 0;
                upd_end   <= 1'b1;
            end else begin
                load_seen <= load_seen + 1;
                upd_end   <= 1'b0;
            end
        end else begin
            upd_end <= 1'b0;
        end
    end

    assign cam_m_tvalid       = pv[LAT-1];
    assign cam_m_tdata        = pd[LAT-1];
    assign cam_update_all_end = upd_end;

    // Monitor: all observations taken mid-cycle, counting what happens at the next edge.
    int            issued = 0, pops = 0, done_cnt = 0, ua_cycles = 0, srch_cycles = 0;
    int            load_hs = 0, mirror_err = 0, sready_bad = 0, mvalid_cnt = 0, ua_to_search = 0;
    int            out_now = 0, max_out = 0;
    logic [2:0]    prev_state = 3'd0;
    logic [RW-1:0] got [$];

    always @(negedge aclk) begin
        if (areset) begin
            out_now    = 0;
            prev_state = 3'd0;
        end else begin
            if (m_tvalid) mvalid_cnt++;
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                pops++;
                out_now--;
            end
            if (cam_tvalid && cam_state == 3'd2) begin
                issued++;
                out_now++;
            end
            if (cam_tvalid && cam_state == 3'd1) load_hs++;
            if (ap_done) done_cnt++;
            if (cam_state == 3'd1) ua_cycles++;
            if (cam_state == 3'd2) srch_cycles++;
            if (prev_state == 3'd1 && cam_state == 3'd2) ua_to_search++;
            if (cam_state != 3'd0 && cam_tvalid !== (s_tvalid && s_tready)) mirror_err++;
            if (s_tready && cam_state != 3'd1 && cam_state != 3'd2) sready_bad++;
            if (out_now > max_out) max_out = out_now;
            prev_state = cam_state;
        end
    end

    int            n_checks = 0, n_errors = 0;
    logic [DW-1:0] beats [$];
    logic [RW-1:0] exp_q [$];
    int            idx = 0;
    bit            drop_on_done = 1'b0;
    int            b_issued, b_done, b_ua, b_srch, b_load, b_got, b_mirror, b_sready, b_mvalid, b_uas;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step(input int vpct, input int rpct);
        bit hs;
        if (idx < beats.size()) begin
            s_tvalid = ($urandom_range(0, 99) < vpct);
            s_tdata  = beats[idx];
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = '0;
        end
        m_tready = ($urandom_range(0, 99) < rpct);
        @(negedge aclk);
        hs = s_tvalid && s_tready;
        if (drop_on_done && ap_done) ap_start = 1'b0;
        @(posedge aclk);
        #1;
        if (hs) idx++;
    endtask

    task automatic start_job(input int n, input bit hold);
        beats.delete();
        exp_q.delete();
        for (int i = 0; i < LOAD_N; i++) beats.push_back(rand_beat());
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] k;
            k = rand_beat();
            beats.push_back(k);
            exp_q.push_back(k[RW-1:0] ^ RES_KEY);
        end
        idx          = 0;
        drop_on_done = hold;
        b_issued = issued; b_done = done_cnt; b_ua = ua_cycles; b_srch = srch_cycles;
        b_load = load_hs; b_got = got.size(); b_mirror = mirror_err; b_sready = sready_bad;
        b_mvalid = mvalid_cnt; b_uas = ua_to_search;
        num_searches = n;
        ap_start     = 1'b1;
        step(100, 100);
        if (!hold) ap_start = 1'b0;
        num_searches = $urandom;
    endtask

    task automatic finish_job(input string name, input int vpct, input int rpct, input int budget);
        int cyc;
        cyc = 0;
        while (done_cnt == b_done && cyc < budget) begin
            step(vpct, rpct);
            cyc++;
        end
        n_checks++;
        if (done_cnt == b_done) begin
            n_errors++;
            $display("FAIL %s timeout: no ap_done within %0d cycles", name, cyc);
        end
        repeat (8) step(0, 100);
        n_checks++;
        if (got.size() - b_got !== exp_q.size()) begin
            n_errors++;
            $display("FAIL %s result_count: got %0d expected %0d", name, got.size() - b_got, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && b_got + i < got.size(); i++) begin
            n_checks++;
            if (got[b_got + i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s result[%0d]: got %h expected %h", name, i, got[b_got + i], exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt - b_done !== 1) begin
            n_errors++;
            $display("FAIL %s ap_done_pulses: got %0d expected 1", name, done_cnt - b_done);
        end
        n_checks++;
        if (issued - b_issued !== exp_q.size()) begin
            n_errors++;
            $display("FAIL %s search_issues: got %0d expected %0d", name, issued - b_issued, exp_q.size());
        end
        n_checks++;
        if (load_hs - b_load !== LOAD_N) begin
            n_errors++;
            $display("FAIL %s load_beats: got %0d expected %0d", name, load_hs - b_load, LOAD_N);
        end
        n_checks++;
        if (mirror_err - b_mirror !== 0) begin
            n_errors++;
            $display("FAIL %s cam_tvalid_mirror: %0d cycles where cam_tvalid != s_tvalid&&s_tready", name, mirror_err - b_mirror);
        end
        n_checks++;
        if (sready_bad - b_sready !== 0) begin
            n_errors++;
            $display("FAIL %s s_tready_outside_load_search: got %0d cycles expected 0", name, sready_bad - b_sready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy_after_job: got %b expected 0", name, busy);
        end
        ap_start = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (ap_done !== 1'b0)    begin n_errors++; $display("FAIL reset ap_done: got %b expected 0", ap_done); end
        n_checks++; if (s_tready !== 1'b0)   begin n_errors++; $display("FAIL reset s_tready: got %b expected 0", s_tready); end
        n_checks++; if (cam_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset cam_tvalid: got %b expected 0", cam_tvalid); end
        n_checks++; if (m_tvalid !== 1'b0)   begin n_errors++; $display("FAIL reset m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (cam_state !== 3'd0)  begin n_errors++; $display("FAIL reset cam_state: got %0d expected 0", cam_state); end
        n_checks++; if (cam_tdata !== '0)    begin n_errors++; $display("FAIL reset cam_tdata: got nonzero expected 0"); end
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_basic();
        start_job(3, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL basic busy_after_start: got %b expected 1", busy); end
        finish_job("basic", 100, 100, 400);
        n_checks++;
        if (ua_cycles - b_ua !== 33) begin
            n_errors++; $display("FAIL basic update_all_cycles: got %0d expected 33", ua_cycles - b_ua);
        end
        n_checks++;
        if (ua_to_search - b_uas !== 1) begin
            n_errors++; $display("FAIL basic update_to_search: got %0d transitions expected 1", ua_to_search - b_uas);
        end
`ifdef CAM_SEQ_PERF_CNT_EN
        n_checks++;
        if (load_cycles !== 32'(ua_cycles - b_ua)) begin
            n_errors++; $display("FAIL basic load_cycles: got %0d expected %0d", load_cycles, ua_cycles - b_ua);
        end
        n_checks++;
        if (search_cycles !== 32'(srch_cycles - b_srch)) begin
            n_errors++; $display("FAIL basic search_cycles: got %0d expected %0d", search_cycles, srch_cycles - b_srch);
        end
`endif
    endtask

    task automatic test_zero_searches();
        start_job(0, 1'b0);
        finish_job("zero", 100, 100, 300);
        n_checks++;
        if (srch_cycles - b_srch !== 0) begin
            n_errors++; $display("FAIL zero search_cycles: got %0d expected 0", srch_cycles - b_srch);
        end
        n_checks++;
        if (ua_cycles - b_ua !== 33) begin
            n_errors++; $display("FAIL zero update_all_cycles: got %0d expected 33", ua_cycles - b_ua);
        end
        n_checks++;
        if (mvalid_cnt - b_mvalid !== 0) begin
            n_errors++; $display("FAIL zero m_tvalid_cycles: got %0d expected 0", mvalid_cnt - b_mvalid);
        end
    endtask

    task automatic test_backpressure();
        start_job(40, 1'b0);
        repeat (120) step(100, 0);
        n_checks++;
        if (issued - b_issued !== DEPTH) begin
            n_errors++; $display("FAIL backpressure issued_while_stalled: got %0d expected %0d", issued - b_issued, DEPTH);
        end
        n_checks++;
        if (out_now !== DEPTH) begin
            n_errors++; $display("FAIL backpressure outstanding: got %0d expected %0d", out_now, DEPTH);
        end
        n_checks++;
        if (m_tvalid !== 1'b1) begin
            n_errors++; $display("FAIL backpressure m_tvalid_stalled: got %b expected 1", m_tvalid);
        end
        finish_job("backpressure", 100, 100, 800);
    endtask

    task automatic test_gappy();
        start_job(20, 1'b0);
        finish_job("gappy", 50, 60, 2000);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 3; j++) begin
            start_job($urandom_range(1, 24), 1'b0);
            finish_job($sformatf("random%0d", j), $urandom_range(30, 100), $urandom_range(20, 100), 3000);
        end
    endtask

    task automatic test_reset_mid_search();
        int cyc;
        start_job(10, 1'b0);
        cyc = 0;
        while (issued - b_issued < 5 && cyc < 300) begin
            step(100, 100);
            cyc++;
        end
        n_checks++;
        if (issued - b_issued !== 5) begin
            n_errors++; $display("FAIL reset_mid issued_before_reset: got %0d expected 5", issued - b_issued);
        end
        areset   = 1'b1;
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        n_checks++; if (cam_state !== 3'd0) begin n_errors++; $display("FAIL reset_mid cam_state: got %0d expected 0", cam_state); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        n_checks++; if (m_tvalid !== 1'b0)  begin n_errors++; $display("FAIL reset_mid m_tvalid: got %b expected 0", m_tvalid); end
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        b_got  = got.size();
        b_done = done_cnt;
        idx    = beats.size();
        repeat (12) step(0, 100);
        n_checks++;
        if (got.size() - b_got !== 0) begin
            n_errors++; $display("FAIL reset_mid stale_results: got %0d expected 0", got.size() - b_got);
        end
        n_checks++;
        if (done_cnt - b_done !== 0) begin
            n_errors++; $display("FAIL reset_mid ap_done_after_abort: got %0d expected 0", done_cnt - b_done);
        end
        start_job(4, 1'b0);
        finish_job("after_reset", 80, 80, 1000);
    endtask

    task automatic test_ignored_start();
        start_job(6, 1'b1);
        finish_job("hold_start", 80, 100, 1000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_searches();
        test_backpressure();
        test_gappy();
        test_random_jobs();
        test_reset_mid_search();
        test_ignored_start();
        n_checks++;
        if (max_out > DEPTH) begin
            n_errors++; $display("FAIL credit_limit max_outstanding: got %0d expected <= %0d", max_out, DEPTH);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_op_sequencer.md
Name: cam_op_sequencer

Overview:
- Controller in front of the CAM compare array (256 entries, 512-bit beats, 8 entries per beat).
- Sequences one job: bulk table load (UPDATE_ALL), then N search beats (SEARCH), then drain.
- The CAM datapath has no backpressure. This block adds credit-based flow control so the result stream to HBM/host can stall safely.
- Results are buffered in a small FIFO and forwarded as AXI-Stream.

Parameters:
- C_DATA_WIDTH, 512, stream/CAM beat width
- CAM_SIZE, 256, CAM entries; load length = CAM_SIZE/8 beats
- OP_CODE_WIDTH, 3, width of cam_state
- SEARCH_LATENCY, 4, cycles from cam_tvalid to cam_m_tvalid while in SEARCH
- RESULT_WIDTH, 32, width of m_tdata; low bits of cam_m_tdata
- FIFO_DEPTH, 16, result FIFO entries; power of 2, >= SEARCH_LATENCY+1

Ports:
- aclk  in  1  clock
- areset  in  1  reset
- ap_start  in  1  job start pulse/level, sampled in IDLE only
- num_searches  in  32  search beats for this job, latched on start
- busy  out  1  high from accepted start until ap_done
- ap_done  out  1  one-cycle pulse at job end
- s_tvalid  in  1  input beat valid (table data, then keys)
- s_tready  out  1  input beat accepted
- s_tdata  in  C_DATA_WIDTH  input beat
- cam_state  out  OP_CODE_WIDTH  opcode to CAM
- cam_tvalid  out  1  beat valid to CAM
- cam_tdata  out  C_DATA_WIDTH  beat to CAM
- cam_update_all_end  in  1  CAM load-complete pulse
- cam_m_tvalid  in  1  CAM result valid
- cam_m_tdata  in  C_DATA_WIDTH  CAM result
- m_tvalid  out  1  result valid
- m_tready  in  1  result sink ready
- m_tdata  out  RESULT_WIDTH  result (match index; all-ones = no match)

Behaviour:
- Reset is synchronous and active-high on areset; clock is aclk.
- Reset values:
  - state = IDLE; cam_state = OP_IDLE (0).
  - busy, ap_done, s_tready, cam_tvalid, m_tvalid = 0.
  - cam_tdata = 0; counters = 0; FIFO empty.
- Reset mid-job aborts: in-flight results are discarded and no ap_done is generated.
- FSM states: IDLE, LOAD, LOAD_WAIT, SEARCH, DRAIN, DONE.
- IDLE:
  - On ap_start: latch num_searches, set busy, go to LOAD.
- LOAD:
  - cam_state = OP_UPDATE_ALL; s_tready = 1; cam_tvalid = s_tvalid; cam_tdata = s_tdata (combinational pass-through).
  - beat_cnt increments on each s_tvalid.
  - After beat CAM_SIZE/8-1 is accepted, go to LOAD_WAIT.
- LOAD_WAIT:
  - cam_state stays OP_UPDATE_ALL; s_tready = 0.
  - On cam_update_all_end: go to SEARCH if num_searches != 0, else go to DONE.
  - cam_update_all_end in any other state is ignored.
- SEARCH:
  - cam_state = OP_SEARCH.
  - A beat is issued (s_tready = 1, cam_tvalid = s_tvalid) only when inflight + fifo_count < FIFO_DEPTH.
  - inflight: +1 on issue, -1 on cam_m_tvalid; net 0 when both occur in the same cycle.
  - After the num_searches-th issue, go to DRAIN.
- DRAIN:
  - cam_state stays OP_SEARCH, because the CAM result pipeline only advances in SEARCH; cam_tvalid = 0.
  - When inflight == 0 and the FIFO is empty, go to DONE.
- DONE:
  - ap_done = 1 for one cycle; busy clears; return to IDLE.
- Result path:
  - cam_m_tvalid pushes cam_m_tdata[RESULT_WIDTH-1:0] into the FIFO.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
  - m_tvalid = FIFO not empty.
  - A pop on m_tvalid && m_tready and a push in the same cycle are both legal and leave the count unchanged.
- num_searches is a 32-bit unsigned count; search_cnt compares equal to it (no wrap within a job).
- ap_start while busy is ignored.

Optional Feature:
- Macro: CAM_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs load_cycles[31:0] and search_cycles[31:0].
  - Both are cleared on accepted ap_start.
  - load_cycles counts cycles spent in LOAD plus LOAD_WAIT.
  - search_cycles counts cycles spent in SEARCH plus DRAIN.
  - Both counters saturate at all-ones and hold their values after DONE.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cam_pkg:
  - Opcode constants: OP_IDLE=0, OP_UPDATE_ALL=1, OP_SEARCH=2, OP_UPDATE_ONE=3.
  - Sequencer state enum typedef.
  - CAM_BEATS_PER_LOAD = CAM_SIZE/8.
- Sub-module cam_result_fifo: synchronous FIFO, depth FIFO_DEPTH, width RESULT_WIDTH, with count output and simultaneous push/pop.

Test Plan:
- Basic job: ap_start with num_searches = 3, 32 load beats streamed, CAM model pulses update_all_end 1 cycle after the last beat. Required: cam_state reads 1 for 33 cycles, then 2; 3 results appear on m_tdata in order; ap_done pulses exactly once.
- Zero searches: num_searches = 0. Required: after update_all_end go straight to DONE; s_tready stays 0 after the load; no m_tvalid.
- Backpressure: m_tready = 0, num_searches = 40. Required: issues stop at 16 outstanding; no FIFO overflow. After m_tready = 1, all 40 results arrive in order and ap_done pulses.
- Gappy input: s_tvalid toggling 1/0 in both LOAD and SEARCH. Required: beat_cnt and search_cnt count only valid beats; cam_tvalid mirrors s_tvalid.
- Reset mid-SEARCH: areset asserted after 5 of 10 searches issued. Required: next cycle cam_state = 0, busy = 0, m_tvalid = 0; a new job then runs cleanly.
- Ignored start: ap_start held high during a running job. Required: the latched num_searches is unchanged and no second job begins until after ap_done.
